// File: rtl/sram_dual_port_arb.sv
// rtl/sram_dual_port_arb.sv - round-robin two-master arbiter for one single-port SRAM, with locked sequences
// Optional power-up zero sweep of the whole array when SRAM_ARB_INIT_CLEAR_EN is defined.
module sram_dual_port_arb #(
    parameter int AW       = 16,
    parameter int LOCK_MAX = 8
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          M0_REQ,
    input  logic [AW-1:0] M0_ADDR,
    input  logic [31:0]   M0_WDATA,
    input  logic [3:0]    M0_WREN,
    input  logic          M0_LOCK,
    output logic          M0_GNT,
    output logic          M0_RVALID,
    output logic [31:0]   M0_RDATA,
    input  logic          M1_REQ,
    input  logic [AW-1:0] M1_ADDR,
    input  logic [31:0]   M1_WDATA,
    input  logic [3:0]    M1_WREN,
    input  logic          M1_LOCK,
    output logic          M1_GNT,
    output logic          M1_RVALID,
    output logic [31:0]   M1_RDATA,
    output logic [AW-1:0] SRAM_ADDR,
    output logic [31:0]   SRAM_WDATA,
    output logic [3:0]    SRAM_WREN,
    output logic          SRAM_CS,
    input  logic [31:0]   SRAM_RDATA,
    output logic          INIT_DONE
);

`ifdef SRAM_ARB_INIT_CLEAR_EN
    typedef enum logic [1:0] {ST_ARB, ST_LOCK0, ST_LOCK1, ST_CLEAR} state_e;
    localparam state_e RESET_STATE = ST_CLEAR;
    logic [AW-1:0] clr_cnt_q, clr_cnt_d;
`else
    typedef enum logic [1:0] {ST_ARB, ST_LOCK0, ST_LOCK1} state_e;
    localparam state_e RESET_STATE = ST_ARB;
`endif

    localparam logic [7:0] LOCK_MAX_C = LOCK_MAX[7:0];

    state_e     state_q, state_d;
    logic       ptr_q, ptr_d;          // 1: M1 wins the next contention
    logic [7:0] lock_cnt_q, lock_cnt_d;
    logic       rv0_q, rv0_d;
    logic       rv1_q, rv1_d;
    logic       gnt0, gnt1, gnt_lock;

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        lock_cnt_d = lock_cnt_q;
        gnt0       = 1'b0;
        gnt1       = 1'b0;
        case (state_q)
            ST_ARB: begin
                if (M0_REQ && (!M1_REQ || !ptr_q)) gnt0 = 1'b1;
                else if (M1_REQ)                   gnt1 = 1'b1;
            end
            ST_LOCK0: gnt0 = M0_REQ;
            ST_LOCK1: gnt1 = M1_REQ;
            default: ;
        endcase
        gnt0     = gnt0 & ~RST;
        gnt1     = gnt1 & ~RST;
        gnt_lock = gnt0 ? M0_LOCK : M1_LOCK;

        if (gnt0 || gnt1) begin
            ptr_d = gnt0;
            if (state_q == ST_ARB) begin
                if (gnt_lock && (LOCK_MAX > 1)) begin
                    state_d    = gnt0 ? ST_LOCK0 : ST_LOCK1;
                    lock_cnt_d = 8'd1;
                end
            end else begin
                lock_cnt_d = lock_cnt_q + 8'd1;
                // Forced release leaves ptr on the other master, so it wins next contention
                if (!gnt_lock || (lock_cnt_d == LOCK_MAX_C)) begin
                    state_d    = ST_ARB;
                    lock_cnt_d = 8'd0;
                end
            end
        end else if ((state_q == ST_LOCK0 && !M0_LOCK) || (state_q == ST_LOCK1 && !M1_LOCK)) begin
            state_d    = ST_ARB;
            lock_cnt_d = 8'd0;
        end

        rv0_d = gnt0 && (M0_WREN == 4'b0000);
        rv1_d = gnt1 && (M1_WREN == 4'b0000);

        SRAM_ADDR  = '0;
        SRAM_WDATA = 32'h0;
        SRAM_WREN  = 4'h0;
        SRAM_CS    = 1'b0;
        if (gnt0) begin
            SRAM_ADDR  = M0_ADDR;
            SRAM_WDATA = M0_WDATA;
            SRAM_WREN  = M0_WREN;
            SRAM_CS    = 1'b1;
        end else if (gnt1) begin
            SRAM_ADDR  = M1_ADDR;
            SRAM_WDATA = M1_WDATA;
            SRAM_WREN  = M1_WREN;
            SRAM_CS    = 1'b1;
        end

`ifdef SRAM_ARB_INIT_CLEAR_EN
        clr_cnt_d = clr_cnt_q;
        if (state_q == ST_CLEAR && !RST) begin
            SRAM_ADDR = clr_cnt_q;
            SRAM_WREN = 4'hF;
            SRAM_CS   = 1'b1;
            clr_cnt_d = clr_cnt_q + 1'b1;
            if (clr_cnt_q == '1) state_d = ST_ARB;
        end
        INIT_DONE = (state_q != ST_CLEAR);
`else
        INIT_DONE = 1'b1;
`endif
    end

    assign M0_GNT    = gnt0;
    assign M1_GNT    = gnt1;
    assign M0_RVALID = rv0_q & ~RST;
    assign M1_RVALID = rv1_q & ~RST;
    assign M0_RDATA  = M0_RVALID ? SRAM_RDATA : 32'h0;
    assign M1_RDATA  = M1_RVALID ? SRAM_RDATA : 32'h0;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= RESET_STATE;
            ptr_q      <= 1'b0;
            lock_cnt_q <= 8'd0;
            rv0_q      <= 1'b0;
            rv1_q      <= 1'b0;
`ifdef SRAM_ARB_INIT_CLEAR_EN
            clr_cnt_q  <= '0;
`endif
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            lock_cnt_q <= lock_cnt_d;
            rv0_q      <= rv0_d;
            rv1_q      <= rv1_d;
`ifdef SRAM_ARB_INIT_CLEAR_EN
            clr_cnt_q  <= clr_cnt_d;
`endif
        end
    end

endmodule

// File: doc/sram_dual_port_arb.md
Name: sram_dual_port_arb

Overview:
- Shares one single-ported synchronous on-chip SRAM (pipelined read, 1-cycle latency; byte-lane write enables; chip select) between two requesters M0 and M1.
- Arbitrates per cycle with round-robin fairness and supports a locked sequence for read-modify-write.
- Sits between the two bus-side masters (e.g. AHB SRAM bridge and DMA) and the SRAM macro.
- Returns read data to the owning requester with a valid strobe.

Parameters:
- AW, 16: SRAM word-address width.
- LOCK_MAX, 8: maximum consecutive locked grants before forced release (range 1..255).

Ports:
- CLK  in  1  system clock; all logic on rising edge.
- RST  in  1  synchronous reset, active-high.
- M0_REQ  in  1  access request; payload held stable until granted.
- M0_ADDR  in  AW  word address.
- M0_WDATA  in  32  write data.
- M0_WREN  in  4  byte write enables; 4'b0000 = read.
- M0_LOCK  in  1  keep ownership after this grant.
- M0_GNT  out  1  access accepted this cycle.
- M0_RVALID  out  1  read data valid.
- M0_RDATA  out  32  read data.
- M1_*  as M0_*  second requester, identical semantics.
- SRAM_ADDR  out  AW  to SRAM ADDR.
- SRAM_WDATA  out  32  to SRAM WDATA.
- SRAM_WREN  out  4  to SRAM WREN.
- SRAM_CS  out  1  to SRAM CS.
- SRAM_RDATA  in  32  from SRAM RDATA.
- INIT_DONE  out  1  arbiter accepting requests.

Behaviour:
- Reset: GNT, RVALID and SRAM_CS = 0 for both masters. SRAM_ADDR, SRAM_WDATA, SRAM_WREN and RDATA = 0. Priority pointer = M0 preferred. Lock counter = 0. State = ARB. INIT_DONE = 1 (macro off).
- Grant is combinational from REQ, state and pointer. At most one GNT per cycle.
- On GNT, the SRAM outputs carry the granted payload with SRAM_CS = 1, captured at the same edge. No grant: CS = 0 and SRAM outputs forced to 0.
- A request completes in the cycle GNT = 1. The master may change its payload or drop REQ the next cycle. Back-to-back grants to one master are allowed.
- Read (WREN = 0) granted in cycle N: Mx_RVALID = 1 in cycle N+1 with Mx_RDATA = SRAM_RDATA. Otherwise RVALID = 0 and RDATA = 0.
- Write: no response strobe. A read in cycle N+1 to the address written in cycle N returns the new data.
- States:
  - ARB:
    - Only one master requesting: grant it.
    - Both requesting: grant the master not granted last. The pointer updates on every grant.
    - If the granted master has LOCK = 1: go to LOCKx, lock counter = 1.
  - LOCKx: only Mx may be granted; the other master's REQ is ignored. Idle cycles inside the lock are allowed.
    - Each Mx grant increments the counter.
    - Return to ARB when Mx is granted with LOCK = 0, or Mx_REQ = 0 with LOCK = 0.
    - Also return to ARB when the counter reaches LOCK_MAX. On this forced release, the pointer points at the other master so it wins the next contention.
- Simultaneous lock release and other-master request: the other master is granted the following cycle, not the same cycle.
- RST mid-operation: a pending RVALID is suppressed, the lock is dropped, the state returns to ARB. SRAM contents are unaffected.

Optional Feature:
- Macro: SRAM_ARB_INIT_CLEAR_EN.
- Defined:
  - After RST, the block enters state CLEAR with INIT_DONE = 0 and both GNT = 0.
  - It writes 32'h0 with WREN = 4'hF, CS = 1 to addresses 0 through 2^AW−1, one per cycle, using an AW-bit counter.
  - It then sets INIT_DONE = 1 and enters ARB. CLEAR takes 2^AW cycles.
  - RST during CLEAR restarts the sweep at address 0.
- Undefined: no CLEAR state. INIT_DONE is tied to 1, and ARB is entered directly from reset.

Test Plan:
- M0 writes addr 0x0010 data 32'hDEADBEEF WREN 4'hF, then reads 0x0010 → GNT same cycle each; M0_RVALID the cycle after the read grant with RDATA 32'hDEADBEEF; M1_RVALID stays 0.
- M0 and M1 request reads continuously from reset → grants alternate M0, M1, M0, M1; each RVALID appears on the matching master one cycle after its grant.
- M0 writes 0x0020 = 32'h11223344, then writes WREN 4'b0100 data 32'h00AA0000, then reads → RDATA 32'h11AA3344.
- M0 holds LOCK = 1 and REQ = 1 while M1 requests, LOCK_MAX = 8 → M0 granted 8 consecutive cycles, then M1 granted; M1_GNT = 0 throughout the lock.
- M1 read granted in cycle N with RST = 1 in cycle N+1 → M1_RVALID = 0 in N+1; all outputs at reset values the following cycle.
- Macro on, AW = 4: after RST, INIT_DONE = 0 for 16 cycles with SRAM_ADDR 0..15 and CS = 1; any REQ ignored; reads of all addresses afterwards return 0.
